// File: rtl/if_id_queue_pkg.sv
// Shared widths, constants and the queue entry type for the IF/ID instruction buffer.
package if_id_queue_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned PC_W   = 32;

    // addi x0,x0,0: decodes to a harmless instruction while the buffer has no valid head
    localparam logic [INST_W-1:0] NOP_INST = 32'h00000013;

    // pc and inst travel as one word so an entry can never be split
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } entry_t;

endpackage : if_id_queue_pkg

// File: rtl/if_id_queue_mem.sv
// DEPTH x entry storage for the IF/ID queue: one synchronous write port, one async read port.
module if_id_queue_mem
    import if_id_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  entry_t        wdata,
    input  logic [AW-1:0] raddr,
    output entry_t        rdata
);

    entry_t mem [DEPTH];

    // Write the offered entry on the rising edge when enabled.
    // NOTE: storage has no reset; validity is tracked by the control counters, so stale data is never presented.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Asynchronous read gives first-word fall-through at the head.
    assign rdata = mem[raddr];

endmodule : if_id_queue_mem

// File: rtl/if_id_queue.sv
// IF/ID instruction buffer: FIFO of {pc, inst} between fetch and decode with flush and NOP padding.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int unsigned       DEPTH    = 2,
    parameter logic [INST_W-1:0] NOP_INST = if_id_queue_pkg::NOP_INST
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PC_W-1:0]   if_pc_i,
    input  logic [INST_W-1:0] if_inst_i,
    input  logic              if_valid_i,
    output logic              if_ready_o,
    input  logic              ctrl_flush_i,
    input  logic              id_ready_i,
    output logic [PC_W-1:0]   ifid_pc_o,
    output logic [INST_W-1:0] ifid_inst_o,
    output logic              ifid_valid_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic   full;
    logic   empty;
    logic   push;
    logic   pop;
    entry_t wr_entry;
    entry_t head;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Ready depends on state only, so a full queue refuses a push even when a pop coincides.
    assign if_ready_o   = ~full;
    assign ifid_valid_o = ~empty & ~ctrl_flush_i;

    assign push = if_valid_i & ~full & ~ctrl_flush_i;
    assign pop  = ifid_valid_o & id_ready_i;

    assign wr_entry = '{pc: if_pc_i, inst: if_inst_i};

    if_id_queue_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Pointer and occupancy update; flush empties the queue and rewinds both pointers.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (ctrl_flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Present the head entry when valid, otherwise a NOP with pc 0.
    // NOTE: outputs get defaults first so every path assigns them and no latch is inferred.
    always_comb begin
        ifid_pc_o   = '0;
        ifid_inst_o = NOP_INST;
        if (ifid_valid_o) begin
            ifid_pc_o   = head.pc;
            ifid_inst_o = head.inst;
        end
    end

    a_count_bound : assert property (@(posedge clk) disable iff (!rst_n) count <= CW'(DEPTH));
    a_no_push_full : assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
    a_no_pop_empty : assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));

endmodule : if_id_queue

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: stimulus queues expected entries, a monitor checks every pop.
module tb_if_id_queue;
    import if_id_queue_pkg::*;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] if_pc_i = '0;
    logic [31:0] if_inst_i = '0;
    logic        if_valid_i = 1'b0;
    logic        if_ready_o;
    logic        ctrl_flush_i = 1'b0;
    logic        id_ready_i = 1'b0;
    logic [31:0] ifid_pc_o;
    logic [31:0] ifid_inst_o;
    logic        ifid_valid_o;

    int checks = 0;
    int errors = 0;
    int pops   = 0;

    logic [63:0] exp_q [$];

    if_id_queue #(
        .DEPTH    (2),
        .NOP_INST (NOP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_pc_i      (if_pc_i),
        .if_inst_i    (if_inst_i),
        .if_valid_i   (if_valid_i),
        .if_ready_o   (if_ready_o),
        .ctrl_flush_i (ctrl_flush_i),
        .id_ready_i   (id_ready_i),
        .ifid_pc_o    (ifid_pc_o),
        .ifid_inst_o  (ifid_inst_o),
        .ifid_valid_o (ifid_valid_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge, then settle for checks.
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                        input logic fl, input logic rdy);
        @(posedge clk);
        #1;
        if_valid_i   = v;
        if_pc_i      = pc;
        if_inst_i    = inst;
        ctrl_flush_i = fl;
        id_ready_i   = rdy;
        #1;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 32'h0, 32'h0, 1'b0, rdy);
    endtask

    // Monitor: every pop must match the oldest expected entry; an invalid head must be NOP/pc 0.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ifid_valid_o && id_ready_i) begin
                pops++;
                if (exp_q.size() == 0) begin
                    check("pop_unexpected", {ifid_pc_o, ifid_inst_o}, 64'hx);
                end else begin
                    check("pop_entry", {ifid_pc_o, ifid_inst_o}, exp_q.pop_front());
                end
            end else if (!ifid_valid_o) begin
                check("idle_nop", {ifid_pc_o, ifid_inst_o}, {32'h0, NOP});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // 1 Reset
        repeat (2) @(posedge clk);
        check("rst_ready_low", {63'h0, if_ready_o}, 64'h1);
        check("rst_valid_low", {63'h0, ifid_valid_o}, 64'h0);
        #1 rst_n = 1'b1;
        #1;
        check("rst_ready", {63'h0, if_ready_o}, 64'h1);
        check("rst_valid", {63'h0, ifid_valid_o}, 64'h0);
        check("rst_inst", {32'h0, ifid_inst_o}, {32'h0, 32'h00000013});
        check("rst_pc", {32'h0, ifid_pc_o}, 64'h0);

        // 2 Stream with decode always ready: count stays at most 1
        step(1'b1, 32'h0, 32'h00100093, 1'b0, 1'b1);
        exp_q.push_back({32'h0, 32'h00100093});
        check("s_ready0", {63'h0, if_ready_o}, 64'h1);
        step(1'b1, 32'h4, 32'h00200113, 1'b0, 1'b1);
        exp_q.push_back({32'h4, 32'h00200113});
        check("s_ready1", {63'h0, if_ready_o}, 64'h1);
        step(1'b1, 32'h8, 32'h00300193, 1'b0, 1'b1);
        exp_q.push_back({32'h8, 32'h00300193});
        check("s_ready2", {63'h0, if_ready_o}, 64'h1);
        idle(1'b1);
        check("s_ready3", {63'h0, if_ready_o}, 64'h1);
        idle(1'b1);
        check("s_drained", {63'h0, ifid_valid_o}, 64'h0);

        // 3 Stall fill, refused third offer, then drain
        step(1'b1, 32'h100, 32'h10000213, 1'b0, 1'b0);
        exp_q.push_back({32'h100, 32'h10000213});
        step(1'b1, 32'h104, 32'h10400293, 1'b0, 1'b0);
        exp_q.push_back({32'h104, 32'h10400293});
        check("f_ready_one", {63'h0, if_ready_o}, 64'h1);
        step(1'b1, 32'h108, 32'h10800313, 1'b0, 1'b0);
        check("f_full", {63'h0, if_ready_o}, 64'h0);
        check("f_head_hold", {32'h0, ifid_pc_o}, {32'h0, 32'h100});
        idle(1'b1);
        check("f_still_full", {63'h0, if_ready_o}, 64'h0);
        idle(1'b1);
        check("f_ready_after_pop", {63'h0, if_ready_o}, 64'h1);
        check("f_head_second", {32'h0, ifid_pc_o}, {32'h0, 32'h104});
        idle(1'b1);
        check("f_empty", {63'h0, ifid_valid_o}, 64'h0);

        // 4 Simultaneous push and pop at count 1
        step(1'b1, 32'h200, 32'h20000393, 1'b0, 1'b0);
        exp_q.push_back({32'h200, 32'h20000393});
        step(1'b1, 32'h204, 32'h20400413, 1'b0, 1'b1);
        exp_q.push_back({32'h204, 32'h20400413});
        idle(1'b0);
        check("pp_head", {32'h0, ifid_pc_o}, {32'h0, 32'h204});
        check("pp_count_one", {63'h0, if_ready_o}, 64'h1);
        idle(1'b1);
        idle(1'b1);

        // 5 Flush with two entries and an offered word
        step(1'b1, 32'h280, 32'h28000493, 1'b0, 1'b0);
        step(1'b1, 32'h284, 32'h28400513, 1'b0, 1'b0);
        step(1'b1, 32'h300, 32'h30000593, 1'b1, 1'b1);
        check("fl_valid", {63'h0, ifid_valid_o}, 64'h0);
        check("fl_nop", {ifid_pc_o, ifid_inst_o}, {32'h0, NOP});
        idle(1'b1);
        check("fl_next_empty", {63'h0, ifid_valid_o}, 64'h0);
        check("fl_next_ready", {63'h0, if_ready_o}, 64'h1);
        step(1'b1, 32'h400, 32'h40000613, 1'b0, 1'b1);
        exp_q.push_back({32'h400, 32'h40000613});
        idle(1'b1);
        idle(1'b1);

        // 6 Asynchronous reset mid-cycle with two entries
        step(1'b1, 32'h500, 32'h50000693, 1'b0, 1'b0);
        step(1'b1, 32'h504, 32'h50400713, 1'b0, 1'b0);
        idle(1'b0);
        check("ar_pre_valid", {63'h0, ifid_valid_o}, 64'h1);
        check("ar_pre_full", {63'h0, if_ready_o}, 64'h0);
        #1 rst_n = 1'b0;
        #1;
        check("ar_valid", {63'h0, ifid_valid_o}, 64'h0);
        check("ar_ready", {63'h0, if_ready_o}, 64'h1);
        check("ar_nop", {ifid_pc_o, ifid_inst_o}, {32'h0, NOP});
        idle(1'b1);
        #1 rst_n = 1'b1;
        idle(1'b1);
        check("ar_after_empty", {63'h0, ifid_valid_o}, 64'h0);

        check("scoreboard_empty", 64'(exp_q.size()), 64'h0);
        check("pop_total", 64'(pops), 64'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_if_id_queue
